// File: rtl/mem_view_pkg.sv
// Shared types and constants for the memory-browse controller.
package mem_view_pkg;

  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    INIT = 2'd0,
    REQ  = 2'd1,
    IDLE = 2'd2
  } view_state_t;

  // Counter width able to hold n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioning: 2-FF synchronizer, debounce filter and rising-edge step pulse.
// Optional hold-to-repeat steps when built with AUTO_REPEAT_EN.
module btn_debounce
  import mem_view_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_DELAY    = 50_000_000,
  parameter int REPEAT_PERIOD   = 20_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic level,
  output logic step
);

  localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);

  logic             r_sync0;
  logic             r_sync1;
  logic             r_level;
  logic             r_step;
  logic [CNT_W-1:0] r_cnt;
  logic             w_accept;
  logic             w_rise;
  logic             w_rep;

  // The new level is taken on the last of DEBOUNCE_CYCLES consecutive disagreeing samples.
  assign w_accept = (r_sync1 != r_level) && (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1));
  assign w_rise   = w_accept && r_sync1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync0 <= 1'b0;
      r_sync1 <= 1'b0;
      r_level <= 1'b0;
      r_cnt   <= '0;
      r_step  <= 1'b0;
    end else begin
      r_sync0 <= btn_raw;
      r_sync1 <= r_sync0;
      if (r_sync1 == r_level) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        r_level <= r_sync1;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      r_step <= w_rise | w_rep;
    end
  end

`ifdef AUTO_REPEAT_EN
  localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int HOLD_W   = cnt_width(HOLD_MAX);

  logic [HOLD_W-1:0] r_hold;
  logic              r_rep_phase;

  // First repeat after REPEAT_DELAY held cycles, then one every REPEAT_PERIOD.
  assign w_rep = r_level &&
                 (r_rep_phase ? (r_hold == HOLD_W'(REPEAT_PERIOD - 1))
                              : (r_hold == HOLD_W'(REPEAT_DELAY - 1)));

  always_ff @(posedge clk) begin
    if (rst || !r_level) begin
      r_hold      <= '0;
      r_rep_phase <= 1'b0;
    end else if (w_rep) begin
      r_hold      <= '0;
      r_rep_phase <= 1'b1;
    end else begin
      r_hold <= r_hold + HOLD_W'(1);
    end
  end
`else
  assign w_rep = 1'b0;
`endif

  assign level = r_level;
  assign step  = r_step;

endmodule

// File: rtl/mem_view_controller.sv
// Memory-browse sequencer: debounced next/prev stepping of a saturating index and a
// request/acknowledge fetch of the addressed word. AUTO_REPEAT_EN enables hold-to-repeat.
module mem_view_controller
  import mem_view_pkg::*;
#(
  parameter int MEM_SIZE        = 17,
  parameter int ADDR_W          = $clog2(MEM_SIZE),
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_DELAY    = 50_000_000,
  parameter int REPEAT_PERIOD   = 20_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              btn_next,
  input  logic              btn_prev,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_ack,
  input  logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] index,
  output logic [DATA_W-1:0] value,
  output logic              value_valid
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(MEM_SIZE - 1);

  logic w_step_next;
  logic w_step_prev;

  btn_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .REPEAT_DELAY    (REPEAT_DELAY),
    .REPEAT_PERIOD   (REPEAT_PERIOD)
  ) u_db_next (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (btn_next),
    .level   (),
    .step    (w_step_next)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .REPEAT_DELAY    (REPEAT_DELAY),
    .REPEAT_PERIOD   (REPEAT_PERIOD)
  ) u_db_prev (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (btn_prev),
    .level   (),
    .step    (w_step_prev)
  );

  view_state_t       r_state;
  view_state_t       w_state_nx;
  logic [ADDR_W-1:0] r_index;
  logic [ADDR_W-1:0] w_index_nx;
  logic              r_rd_req;
  logic              w_rd_req_nx;
  logic [DATA_W-1:0] r_value;
  logic [DATA_W-1:0] w_value_nx;
  logic              r_valid;
  logic              w_valid_nx;
  logic              w_go_next;
  logic              w_go_prev;

  // Simultaneous steps cancel; a step past either end is a no-op.
  assign w_go_next = w_step_next && !w_step_prev && (r_index < LAST_IDX);
  assign w_go_prev = w_step_prev && !w_step_next && (r_index != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= INIT;
      r_index  <= '0;
      r_rd_req <= 1'b0;
      r_value  <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_index  <= w_index_nx;
      r_rd_req <= w_rd_req_nx;
      r_value  <= w_value_nx;
      r_valid  <= w_valid_nx;
    end
  end

  always_comb begin
    w_state_nx  = r_state;
    w_index_nx  = r_index;
    w_rd_req_nx = r_rd_req;
    w_value_nx  = r_value;
    w_valid_nx  = r_valid;
    unique case (r_state)
      INIT: begin
        w_state_nx  = REQ;
        w_rd_req_nx = 1'b1;
      end
      REQ: begin
        // Steps are dropped here; index and address stay frozen until the ack.
        if (rd_ack) begin
          w_value_nx  = rd_data;
          w_valid_nx  = 1'b1;
          w_rd_req_nx = 1'b0;
          w_state_nx  = IDLE;
        end
      end
      IDLE: begin
        if (w_go_next) begin
          w_index_nx  = r_index + ADDR_W'(1);
          w_valid_nx  = 1'b0;
          w_rd_req_nx = 1'b1;
          w_state_nx  = REQ;
        end else if (w_go_prev) begin
          w_index_nx  = r_index - ADDR_W'(1);
          w_valid_nx  = 1'b0;
          w_rd_req_nx = 1'b1;
          w_state_nx  = REQ;
        end
      end
      default: begin
        w_state_nx  = INIT;
        w_rd_req_nx = 1'b0;
      end
    endcase
  end

  assign rd_req      = r_rd_req;
  assign rd_addr     = r_index;
  assign index       = r_index;
  assign value       = r_value;
  assign value_valid = r_valid;

endmodule

// File: tb/tb_mem_view_controller.sv
// Randomized bench for mem_view_controller with an in-bench behavioural model and directed scenarios.
`timescale 1ns/1ps
module tb_mem_view_controller;

  localparam int DEB  = 4;
  localparam int RDLY = 20;
  localparam int RPER = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        btn_next;
  logic        btn_prev;
  logic        rd_req;
  logic [4:0]  rd_addr;
  logic        rd_ack  = 1'b0;
  logic [15:0] rd_data = 16'h0000;
  logic [4:0]  index;
  logic [15:0] value;
  logic        value_valid;

  always #5 clk = ~clk;

  mem_view_controller #(
    .MEM_SIZE        (17),
    .DEBOUNCE_CYCLES (DEB),
    .REPEAT_DELAY    (RDLY),
    .REPEAT_PERIOD   (RPER)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_next    (btn_next),
    .btn_prev    (btn_prev),
    .rd_req      (rd_req),
    .rd_addr     (rd_addr),
    .rd_ack      (rd_ack),
    .rd_data     (rd_data),
    .index       (index),
    .value       (value),
    .value_valid (value_valid)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h time=%0t", name, act, exp, $time);
    end
  endtask

  // Memory: word i = 16'hA000+i, acked once rd_req has been high for more than ack_lat cycles.
  int ack_lat     = 1;
  int req_age     = 0;
  bit spurious_en = 1'b0;
  int fetches     = 0;
  bit prev_req    = 1'b0;

  always @(negedge clk) begin
    if (rd_req === 1'b1) begin
      if (!prev_req) fetches++;
      req_age++;
      rd_ack  = (req_age > ack_lat);
      rd_data = rd_ack ? (16'hA000 + 16'(rd_addr)) : 16'h5A5A;
    end else begin
      req_age = 0;
      rd_ack  = spurious_en && ($urandom_range(0, 3) == 0);
      rd_data = 16'hDEAD;
    end
    prev_req = (rd_req === 1'b1);
  end

  // Behavioural model: raw -> 2-cycle delay -> sliding window of DEB samples -> level/step,
  // and a browse index that fetches after each accepted step.
  bit          m_sh  [2][2];
  bit          m_win [2][DEB];
  bit          m_lvl [2];
  bit          m_stp [2];
  int          m_t   [2];
  logic [4:0]  m_index   = '0;
  logic [15:0] m_value   = '0;
  bit          m_valid   = 1'b0;
  bit          m_pending = 1'b0;
  bit          m_start   = 1'b1;

  always @(posedge clk) begin : model
    bit raw [2];
    bit sn, sp, s, flip, ns;
    raw[0] = btn_next;
    raw[1] = btn_prev;
    sn = m_stp[0];
    sp = m_stp[1];
    if (rst) begin
      m_index = '0; m_value = '0; m_valid = 1'b0; m_pending = 1'b0; m_start = 1'b1;
      for (int b = 0; b < 2; b++) begin
        m_sh[b][0] = 1'b0; m_sh[b][1] = 1'b0;
        for (int i = 0; i < DEB; i++) m_win[b][i] = 1'b0;
        m_lvl[b] = 1'b0; m_stp[b] = 1'b0; m_t[b] = 0;
      end
    end else begin
      if (m_start) begin
        m_start = 1'b0; m_pending = 1'b1;
      end else if (m_pending) begin
        if (rd_ack === 1'b1) begin
          m_value = 16'hA000 + 16'(m_index); m_valid = 1'b1; m_pending = 1'b0;
        end
      end else if (sn && !sp) begin
        if (m_index < 5'd16) begin m_index = m_index + 5'd1; m_valid = 1'b0; m_pending = 1'b1; end
      end else if (sp && !sn) begin
        if (m_index > 5'd0) begin m_index = m_index - 5'd1; m_valid = 1'b0; m_pending = 1'b1; end
      end
      for (int b = 0; b < 2; b++) begin
        s = m_sh[b][1]; m_sh[b][1] = m_sh[b][0]; m_sh[b][0] = raw[b];
        for (int i = DEB - 1; i > 0; i--) m_win[b][i] = m_win[b][i-1];
        m_win[b][0] = s;
        ns = 1'b0;
`ifdef AUTO_REPEAT_EN
        if (m_lvl[b]) begin
          m_t[b]++;
          if (m_t[b] == RDLY || (m_t[b] > RDLY && (m_t[b] - RDLY) % RPER == 0)) ns = 1'b1;
        end else begin
          m_t[b] = 0;
        end
`endif
        flip = 1'b1;
        for (int i = 0; i < DEB; i++) if (m_win[b][i] == m_lvl[b]) flip = 1'b0;
        if (flip) begin
          m_lvl[b] = !m_lvl[b];
          if (m_lvl[b]) ns = 1'b1;
        end
        m_stp[b] = ns;
      end
    end
  end

  bit cmp_en = 1'b0;
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model_index",   index,       m_index);
      chk("model_rd_addr", rd_addr,     m_index);
      chk("model_rd_req",  rd_req,      m_pending);
      chk("model_value",   value,       m_value);
      chk("model_valid",   value_valid, m_valid);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (!(value_valid === 1'b1 && rd_req === 1'b0) && n < budget) begin
      @(negedge clk); n++;
    end
    chk({name, "_settled"}, (value_valid === 1'b1 && rd_req === 1'b0), 1);
  endtask

  task automatic wait_req(input string name, input int budget);
    int n = 0;
    while (rd_req !== 1'b1 && n < budget) begin
      @(negedge clk); n++;
    end
    chk(name, rd_req, 1);
  endtask

  task automatic press(input bit nxt, input bit prv);
    btn_next = nxt; btn_prev = prv;
    cyc(DEB + 6);
    btn_next = 1'b0; btn_prev = 1'b0;
    cyc(DEB + 6);
  endtask

  task automatic do_reset();
    rst = 1'b1; cyc(2); rst = 1'b0;
    wait_idle("reset", 8);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int f;
    logic [4:0] i0, a0;
    bit changed;
    rst = 1'b1; btn_next = 1'b0; btn_prev = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    cmp_en = 1'b1;
    chk("rst_index", index, 0);
    chk("rst_rd_req", rd_req, 0);
    chk("rst_value", value, 16'h0000);
    chk("rst_valid", value_valid, 0);

    f = fetches;
    rst = 1'b0;
    wait_idle("boot", 4);
    chk("boot_value", value, 16'hA000);
    chk("boot_fetches", fetches - f, 1);

    f = fetches;
    repeat (3) press(1'b1, 1'b0);
    wait_idle("three", 10);
    chk("three_index", index, 3);
    chk("three_value", value, 16'hA003);
    chk("three_fetches", fetches - f, 3);

    do_reset();
    f = fetches;
    for (int i = 0; i < 10; i++) begin btn_next = ~btn_next; cyc(1); end
    press(1'b1, 1'b0);
    wait_idle("bounce", 10);
    chk("bounce_index", index, 1);
    chk("bounce_fetches", fetches - f, 1);

    repeat (15) press(1'b1, 1'b0);
    wait_idle("top", 10);
    chk("top_index", index, 16);
    chk("top_value", value, 16'hA010);
    f = fetches;
    press(1'b1, 1'b0);
    chk("sat_hi_index", index, 16);
    chk("sat_hi_fetches", fetches - f, 0);
    chk("sat_hi_valid", value_valid, 1);

    do_reset();
    f = fetches;
    press(1'b0, 1'b1);
    chk("sat_lo_index", index, 0);
    chk("sat_lo_fetches", fetches - f, 0);
    chk("sat_lo_valid", value_valid, 1);

    press(1'b1, 1'b0);
    f = fetches;
    press(1'b1, 1'b1);
    chk("both_index", index, 1);
    chk("both_fetches", fetches - f, 0);

    ack_lat = 16;
    f = fetches; i0 = index;
    btn_next = 1'b1;
    wait_req("dly_req", 20);
    a0 = rd_addr; changed = 1'b0;
    btn_next = 1'b0;
    for (int i = 0; i < 6; i++) begin @(negedge clk); if (rd_req === 1'b1 && rd_addr !== a0) changed = 1'b1; end
    btn_next = 1'b1;
    for (int i = 0; i < 8; i++) begin @(negedge clk); if (rd_req === 1'b1 && rd_addr !== a0) changed = 1'b1; end
    btn_next = 1'b0;
    for (int i = 0; i < 20 && rd_req === 1'b1; i++) begin @(negedge clk); if (rd_req === 1'b1 && rd_addr !== a0) changed = 1'b1; end
    wait_idle("dly", 20);
    cyc(12);
    chk("dly_addr_held", changed, 0);
    chk("dly_index", index, i0 + 5'd1);
    chk("dly_fetches", fetches - f, 1);
    ack_lat = 1;

`ifdef AUTO_REPEAT_EN
    do_reset();
    btn_next = 1'b1;
    for (int i = 0; i < 30 && index !== 5'd1; i++) @(negedge clk);
    cyc(49);
    btn_next = 1'b0;
    cyc(30);
    chk("repeat_index", index, 6);
    chk("repeat_value", value, 16'hA006);
`endif

    ack_lat = 8;
    btn_next = 1'b1;
    wait_req("rstreq_req", 20);
    btn_next = 1'b0;
    cyc(2);
    rst = 1'b1;
    @(negedge clk);
    chk("rstreq_rd_req", rd_req, 0);
    chk("rstreq_index", index, 0);
    rst = 1'b0; ack_lat = 1;
    wait_req("rstreq_refetch", 4);
    chk("rstreq_addr", rd_addr, 0);
    wait_idle("rstreq", 4);
    chk("rstreq_value", value, 16'hA000);

    spurious_en = 1'b1;
    for (int seg = 0; seg < 250; seg++) begin
      ack_lat = $urandom_range(1, 4);
      if ($urandom_range(0, 99) < 3) begin
        rst = 1'b1; cyc(1 + $urandom_range(0, 1)); rst = 1'b0;
      end else begin
        btn_next = ($urandom_range(0, 2) == 0);
        btn_prev = ($urandom_range(0, 3) == 0);
        cyc($urandom_range(1, 14));
      end
    end
    btn_next = 1'b0; btn_prev = 1'b0;
    cyc(30);
    spurious_en = 1'b0;
    cyc(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
